// File: rtl/daq_sweep_sequencer.sv
// daq_sweep_sequencer
// Steps a DAC code through a configured sweep. For each point it fires one
// start pulse at the downstream DAQ controller and waits for conversion
// complete, keeping the last ADC sample seen. It then offers
// (index, code, sample) on a valid/ready result port. A per-point watchdog
// ends the sweep with a sticky error if the controller never completes, and
// abort ends the sweep at any point. Reset is synchronous and active-low.

module daq_sweep_sequencer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,

    // sweep request and configuration
    input  logic        go,
    input  logic        abort,
    input  logic [11:0] cfg_start_code,
    input  logic [11:0] cfg_step,
    input  logic [8:0]  cfg_npoints,

    // downstream DAQ controller
    output logic        ctl_start,
    output logic [11:0] ctl_dac_code,
    input  logic        ctl_done,
    input  logic        adc_valid,
    input  logic [11:0] adc_data,

    // per-point result stream
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_index,
    output logic [11:0] res_code,
    output logic [11:0] res_data,

    // status
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    // The WAIT timer only has to reach TIMEOUT_CYCLES-1. It needs at least
    // one bit so that a degenerate TIMEOUT_CYCLES of 1 still elaborates.
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_FINISH
    } state_t;

    state_t state_q;
    state_t state_d;

    // sweep configuration captured on an accepted go
    logic [11:0] start_q;
    logic [11:0] step_q;
    logic [8:0]  npoints_q;

    // per-point progress
    logic [7:0]  idx_q;      // current point number
    logic [11:0] acc_q;      // accumulated step offset from the start code, mod 4096
    logic [11:0] cap_q;      // last ADC sample captured in WAIT
    logic [TW-1:0] timer_q;  // WAIT cycles spent on this point
    logic        err_q;

    // control strobes from the next-state logic to the datapath
    logic ld_cfg;
    logic advance;
    logic clr_point;
    logic cap_en;
    logic inc_timer;
    logic set_err;

    logic last_point;
    logic timer_expired;

    // The current point is the last one when index + 1 equals npoints.
    // This form avoids npoints-1 underflowing for an empty sweep.
    assign last_point    = (({1'b0, idx_q} + 9'd1) == npoints_q);
    assign timer_expired = (timer_q == TIMER_LAST);

    // State register.
    // NOTE: sequential state is assigned with <= only, so every register
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes. abort comes first in every
    // active state, so it beats ctl_done, the timeout and the result handshake.
    // NOTE: every signal gets a default before the case statement so that
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        ld_cfg    = 1'b0;
        advance   = 1'b0;
        clr_point = 1'b0;
        cap_en    = 1'b0;
        inc_timer = 1'b0;
        set_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ld_cfg  = 1'b1;
                    state_d = (cfg_npoints == 9'd0) ? S_FINISH : S_ISSUE;
                end
            end

            S_ISSUE: begin
                // A fresh point: restart the watchdog and forget old samples.
                clr_point = 1'b1;
                state_d   = abort ? S_FINISH : S_WAIT;
            end

            S_WAIT: begin
                // A sample that arrives together with ctl_done is still kept.
                cap_en = adc_valid;
                if (abort) begin
                    state_d = S_FINISH;
                end else if (ctl_done) begin
                    state_d = S_EMIT;
                end else if (timer_expired) begin
                    set_err = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    inc_timer = 1'b1;
                end
            end

            S_EMIT: begin
                if (abort) begin
                    state_d = S_FINISH;
                end else if (res_ready) begin
                    if (last_point) begin
                        state_d = S_FINISH;
                    end else begin
                        advance = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sweep configuration. It is captured only on an accepted go, so cfg_*
    // may change freely while a sweep is running.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            start_q   <= 12'h000;
            step_q    <= 12'h000;
            npoints_q <= 9'd0;
        end else if (ld_cfg) begin
            start_q   <= cfg_start_code;
            step_q    <= cfg_step;
            npoints_q <= cfg_npoints;
        end
    end

    // Point index and code offset. Both are cleared on go and advanced
    // after each accepted result. The offset wraps silently at 4096.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx_q <= 8'd0;
            acc_q <= 12'h000;
        end else if (ld_cfg) begin
            idx_q <= 8'd0;
            acc_q <= 12'h000;
        end else if (advance) begin
            idx_q <= idx_q + 8'd1;
            acc_q <= acc_q + step_q;
        end
    end

    // ADC capture. The register clears at ISSUE so that a point with no
    // sample reports 0, and each later sample in WAIT overwrites it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_q <= 12'h000;
        end else if (clr_point) begin
            cap_q <= 12'h000;
        end else if (cap_en) begin
            cap_q <= adc_data;
        end
    end

    // Per-point WAIT watchdog. It stops counting at the expiry value because
    // the FSM leaves WAIT on that cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q <= '0;
        end else if (clr_point) begin
            timer_q <= '0;
        end else if (inc_timer) begin
            timer_q <= timer_q + TW'(1);
        end
    end

    // Sticky timeout flag. Only the next accepted go clears it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (ld_cfg) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end

    // Outputs decode from the state and registers. The code is start plus
    // offset, so it holds still from ISSUE through EMIT. After reset every
    // output is 0.
    assign ctl_start    = (state_q == S_ISSUE);
    assign ctl_dac_code = start_q + acc_q;
    assign res_valid    = (state_q == S_EMIT);
    assign res_index    = idx_q;
    assign res_code     = ctl_dac_code;
    assign res_data     = cap_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_FINISH);
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_daq_sweep_sequencer.sv
// Bench for daq_sweep_sequencer. A behavioural DAQ controller answers each
// ctl_start. The reference model computes each expected result directly from
// the sweep rules and pushes it into a scoreboard queue when the sweep is
// requested. A separate monitor pops and compares at every result handshake.

module tb_daq_sweep_sequencer;

    localparam int TMO = 16;

    logic        clk;
    logic        reset_n;
    logic        go;
    logic        abort;
    logic [11:0] cfg_start_code;
    logic [11:0] cfg_step;
    logic [8:0]  cfg_npoints;
    logic        ctl_start;
    logic [11:0] ctl_dac_code;
    logic        ctl_done;
    logic        adc_valid;
    logic [11:0] adc_data;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_index;
    logic [11:0] res_code;
    logic [11:0] res_data;
    logic        busy;
    logic        done;
    logic        err_timeout;

    daq_sweep_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .go             (go),
        .abort          (abort),
        .cfg_start_code (cfg_start_code),
        .cfg_step       (cfg_step),
        .cfg_npoints    (cfg_npoints),
        .ctl_start      (ctl_start),
        .ctl_dac_code   (ctl_dac_code),
        .ctl_done       (ctl_done),
        .adc_valid      (adc_valid),
        .adc_data       (adc_data),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_index      (res_index),
        .res_code       (res_code),
        .res_data       (res_data),
        .busy           (busy),
        .done           (done),
        .err_timeout    (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  idx;
        logic [11:0] code;
        logic [11:0] data;
    } res_t;

    res_t sb_q[$];

    int n_checks  = 0;
    int n_errors  = 0;
    int n_start   = 0;
    int n_done    = 0;
    int n_results = 0;

    // environment knobs
    int          rdy_mode  = 0;  // 0: always ready, 1: random, 2: held low
    int          cap_mode  = 0;  // 0: junk then sample with done, 1: sample before done, 2: no sample
    int          fixed_lat = 4;  // 0 selects a random latency of 1..6
    bit          ctl_never = 1'b0;
    logic [11:0] salt      = 12'h001;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: point i uses code (start + i*step) mod 4096. Its sample
    // is code+salt, or 0 when the controller returns no sample.
    task automatic push_expected(input int start, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            res_t r;
            r.idx  = 8'(i);
            r.code = 12'((start + i * step) % 4096);
            r.data = (cap_mode == 2) ? 12'h000 : 12'((int'(r.code) + int'(salt)) % 4096);
            sb_q.push_back(r);
        end
    endtask

    // go for one cycle, then scramble cfg_* to show they are not resampled
    task automatic pulse_go(input int start, input int step, input int n);
        cfg_start_code = 12'(start);
        cfg_step       = 12'(step);
        cfg_npoints    = 9'(n);
        go             = 1'b1;
        tick();
        go             = 1'b0;
        cfg_start_code = 12'($urandom);
        cfg_step       = 12'($urandom);
        cfg_npoints    = 9'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < budget);
        check("done_pulse", 32'(done), 32'd1);
        tick();
        check("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic wait_res_valid(input int budget);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!res_valid && cyc < budget);
        check("res_valid_seen", 32'(res_valid), 32'd1);
    endtask

    task automatic run_sweep(input int start, input int step, input int n, input string tag);
        int s0 = n_start;
        int d0 = n_done;
        push_expected(start, step, n);
        pulse_go(start, step, n);
        wait_done(n * 40 + 60);
        check({tag, "_ctl_starts"}, 32'(n_start - s0), 32'(n));
        check({tag, "_done_count"}, 32'(n_done - d0), 32'd1);
        check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    endtask

    // Result consumer: changes res_ready shortly after each rising edge.
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       res_ready = 1'b1;
                1:       res_ready = 1'($urandom_range(0, 1));
                default: res_ready = 1'b0;
            endcase
        end
    end

    // DAQ controller: ctl_done arrives 'lat' cycles after the ctl_start
    // cycle, with ADC strobes placed according to cap_mode.
    initial begin
        ctl_done  = 1'b0;
        adc_valid = 1'b0;
        adc_data  = 12'h000;
        forever begin
            @(negedge clk);
            if (reset_n && ctl_start && !ctl_never) begin
                logic [11:0] code;
                int lat;
                code = ctl_dac_code;
                lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6));
                for (int k = 1; k <= lat; k++) begin
                    tick();
                    ctl_done  = 1'b0;
                    adc_valid = 1'b0;
                    if (cap_mode != 2 && k == 1 && lat >= 3) begin
                        adc_valid = 1'b1;
                        adc_data  = 12'($urandom);
                    end
                    if (cap_mode == 1 && lat >= 2 && k == lat - 1) begin
                        adc_valid = 1'b1;
                        adc_data  = code + salt;
                    end
                    if (k == lat) begin
                        ctl_done = 1'b1;
                        if (cap_mode == 0 || (cap_mode == 1 && lat < 2)) begin
                            adc_valid = 1'b1;
                            adc_data  = code + salt;
                        end
                    end
                end
                tick();
                ctl_done  = 1'b0;
                adc_valid = 1'b0;
            end
        end
    end

    // Monitor: counts pulses, pops the scoreboard at each handshake and checks
    // that results do not change while the consumer stalls.
    initial begin
        bit          stall_prev = 1'b0;
        logic [7:0]  p_idx      = '0;
        logic [11:0] p_code     = '0;
        logic [11:0] p_data     = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (ctl_start) n_start++;
                if (done) n_done++;
                if (stall_prev) begin
                    check("stall_valid", 32'(res_valid), 32'd1);
                    check("stall_index", 32'(res_index), 32'(p_idx));
                    check("stall_code", 32'(res_code), 32'(p_code));
                    check("stall_data", 32'(res_data), 32'(p_data));
                end
                if (res_valid && res_ready) begin
                    n_results++;
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_result", 32'(sb_q.size()), 32'd1);
                    end else begin
                        res_t e;
                        e = sb_q.pop_front();
                        check("res_index", 32'(res_index), 32'(e.idx));
                        check("res_code", 32'(res_code), 32'(e.code));
                        check("res_data", 32'(res_data), 32'(e.data));
                    end
                end
                stall_prev = res_valid && !res_ready;
                p_idx      = res_index;
                p_code     = res_code;
                p_data     = res_data;
            end
        end
    end

    // Watchdog: stop the run if something hangs.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s0;
        int d0;
        int r0;
        int st;
        int seen;
        logic [7:0]  b_idx;
        logic [11:0] b_code;
        logic [11:0] b_data;

        reset_n        = 1'b0;
        go             = 1'b0;
        abort          = 1'b0;
        cfg_start_code = 12'h000;
        cfg_step       = 12'h000;
        cfg_npoints    = 9'd0;

        // ---- reset state ----
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ctl_start", 32'(ctl_start), 32'd0);
        check("rst_ctl_dac_code", 32'(ctl_dac_code), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_index", 32'(res_index), 32'd0);
        check("rst_res_code", 32'(res_code), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_err_timeout", 32'(err_timeout), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // ---- basic sweep: 3 points, done 4 cycles after start, data = code+1 ----
        rdy_mode  = 0;
        cap_mode  = 0;
        fixed_lat = 4;
        salt      = 12'h001;
        run_sweep(12'h100, 12'h010, 3, "basic");

        // ---- wrap of the code register ----
        salt = 12'h123;
        run_sweep(12'hFF0, 12'h020, 2, "wrap");

        // ---- backpressure at point 0 ----
        rdy_mode = 2;
        s0       = n_start;
        st       = int'($urandom_range(0, 4095));
        push_expected(st, 12'h00F, 2);
        pulse_go(st, 12'h00F, 2);
        wait_res_valid(50);
        b_idx  = res_index;
        b_code = res_code;
        b_data = res_data;
        check("bp_first_index", 32'(b_idx), 32'd0);
        check("bp_first_code", 32'(b_code), 32'(st));
        for (int k = 0; k < 10; k++) begin
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_index", 32'(res_index), 32'(b_idx));
            check("bp_hold_code", 32'(res_code), 32'(b_code));
            check("bp_hold_data", 32'(res_data), 32'(b_data));
            check("bp_no_ctl_start", 32'(ctl_start), 32'd0);
            @(negedge clk);
        end
        check("bp_starts_during_stall", 32'(n_start - s0), 32'd1);
        rdy_mode = 0;
        wait_done(200);
        check("bp_ctl_starts", 32'(n_start - s0), 32'd2);
        check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- timeout: controller never completes ----
        ctl_never = 1'b1;
        s0        = n_start;
        r0        = n_results;
        pulse_go(12'h200, 12'h001, 3);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (ctl_start) seen = 1;
        end
        check("tmo_ctl_start_seen", 32'(seen), 32'd1);
        // First WAIT cycle is one after ISSUE; done lands 16 cycles after that.
        for (int i = 1; i <= TMO + 1; i++) begin
            @(negedge clk);
            if (i == TMO) begin
                check("tmo_no_early_done", 32'(done), 32'd0);
                check("tmo_no_early_err", 32'(err_timeout), 32'd0);
            end
        end
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_err", 32'(err_timeout), 32'd1);
        @(negedge clk);
        check("tmo_busy_low", 32'(busy), 32'd0);
        check("tmo_err_sticky", 32'(err_timeout), 32'd1);
        check("tmo_single_start", 32'(n_start - s0), 32'd1);
        check("tmo_no_results", 32'(n_results - r0), 32'd0);
        tick();
        ctl_never = 1'b0;
        push_expected(12'h3A0, 12'h001, 1);
        pulse_go(12'h3A0, 12'h001, 1);
        check("tmo_err_cleared_by_go", 32'(err_timeout), 32'd0);
        wait_done(100);
        check("tmo_recover_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- npoints = 0, with a go coincident with done ----
        s0             = n_start;
        d0             = n_done;
        cfg_start_code = 12'h555;
        cfg_step       = 12'h001;
        cfg_npoints    = 9'd0;
        go             = 1'b1;
        tick();
        cfg_npoints = 9'd5;  // go held into the done cycle: must be ignored
        @(negedge clk);
        check("np0_done", 32'(done), 32'd1);
        check("np0_busy", 32'(busy), 32'd1);
        tick();
        go = 1'b0;
        check("np0_busy_after", 32'(busy), 32'd0);
        repeat (6) tick();
        check("np0_no_ctl_start", 32'(n_start - s0), 32'd0);
        check("np0_done_count", 32'(n_done - d0), 32'd1);
        check("np0_still_idle", 32'(busy), 32'd0);

        // ---- abort in WAIT of point 1 of a 5-point sweep ----
        fixed_lat = 6;
        cap_mode  = 0;
        s0        = n_start;
        r0        = n_results;
        push_expected(12'h040, 12'h100, 1);
        pulse_go(12'h040, 12'h100, 5);
        seen = 0;
        for (int c = 0; c < 60 && seen < 2; c++) begin
            @(negedge clk);
            if (ctl_start) seen++;
        end
        check("abort_second_issue", 32'(seen), 32'd2);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_done", 32'(done), 32'd1);
        tick();
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_err_unchanged", 32'(err_timeout), 32'd0);
        repeat (10) tick();
        check("abort_one_result", 32'(n_results - r0), 32'd1);
        check("abort_ctl_starts", 32'(n_start - s0), 32'd2);
        check("abort_sb_empty", 32'(sb_q.size()), 32'd0);

        // ---- reset in EMIT while stalled ----
        fixed_lat = 3;
        rdy_mode  = 2;
        d0        = n_done;
        pulse_go(12'h700, 12'h011, 3);
        wait_res_valid(50);
        #1;
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_emit_busy", 32'(busy), 32'd0);
        check("rst_emit_res_valid", 32'(res_valid), 32'd0);
        check("rst_emit_done", 32'(done), 32'd0);
        check("rst_emit_index", 32'(res_index), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (8) tick();
        check("rst_emit_no_done", 32'(n_done - d0), 32'd0);
        rdy_mode = 0;
        salt     = 12'h0A5;
        run_sweep(12'h321, 12'h004, 2, "restart");

        // ---- randomized sweeps, including a 1-point and a full 256-point sweep ----
        for (int t = 0; t < 14; t++) begin
            int n;
            cap_mode  = int'($urandom_range(0, 2));
            fixed_lat = 0;
            rdy_mode  = 1;
            salt      = 12'($urandom);
            if (t == 12)      n = 1;
            else if (t == 13) n = 256;
            else              n = int'($urandom_range(2, 10));
            run_sweep(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), n, "rand");
            repeat (int'($urandom_range(0, 3))) tick();
        end

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
